// File: rtl/noc_tree_pkg.sv
// Shared types and helpers for the tree-NoC input controller.
package noc_tree_pkg;

  // Output stage: nothing held, or one packet waiting for its target port.
  typedef enum logic [0:0] {
    StIdle,
    StHold
  } out_state_e;

  localparam int unsigned PortIdxW = 8;
  localparam int unsigned MaxDestW = 32;

  // Result of routing one packet head.
  typedef struct packed {
    logic [PortIdxW-1:0] port;
    logic                illegal;
  } route_t;

  // Extract value[msb -: len], right-aligned; a zero-length slice reads as 0.
  function automatic logic [MaxDestW-1:0] dest_slice(input logic [MaxDestW-1:0] value,
                                                     input int unsigned msb,
                                                     input int unsigned len);
    logic [MaxDestW-1:0] mask;
    if (len == 0) return '0;
    mask = (len >= MaxDestW) ? '1 : (({{(MaxDestW-1){1'b0}}, 1'b1} << len) - 1'b1);
    return (value >> (msb + 1 - len)) & mask;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; no bypass, full and empty are registered-pointer derived.
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (2**AW) != DEPTH) begin : g_bad_depth
    $fatal(1, "noc_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset empties the FIFO without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/input_ctrl_nway.sv
// Router input port: buffers packets, routes each head to one child or the parent port,
// drops illegal packets and counts deliveries and drops.
module input_ctrl_nway
  import noc_tree_pkg::*;
#(
  parameter int unsigned          WIDTH_packet = 14,
  parameter int unsigned          WIDTH_dest   = 3,
  parameter int unsigned          CBITS        = 1,
  parameter int unsigned          LEVEL        = 0,
  parameter logic [WIDTH_dest-1:0] ADDR        = '0,
  parameter bit                   IS_ROOT      = 1'b0,
  parameter bit                   FROM_PARENT  = 1'b0,
  parameter int unsigned          DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH_packet-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH_packet-1:0] out_data,
  output logic [2**CBITS:0]       out_valid,
  input  logic [2**CBITS:0]       out_ready,
  output logic [15:0]             pkt_count,
  output logic [15:0]             err_count
);

  localparam int unsigned NUM_CHILD = 2**CBITS;
  localparam int unsigned NUM_OUT   = NUM_CHILD + 1;
  localparam int unsigned P         = LEVEL * CBITS;

  if ((LEVEL + 1) * CBITS > WIDTH_dest) begin : g_bad_level
    $fatal(1, "input_ctrl_nway: (LEVEL+1)*CBITS exceeds WIDTH_dest");
  end

  logic [WIDTH_packet-1:0] head;
  logic                    full, empty, push, pop;
  logic                    alive_q;
  route_t                  head_route;
  logic [MaxDestW-1:0]     dest_ext, addr_ext;
  logic                    prefix_match;

  out_state_e              state_q, state_d;
  logic [WIDTH_packet-1:0] data_q;
  logic [NUM_OUT-1:0]      valid_q;
  logic [15:0]             pkt_q, err_q;
  logic                    load, drop, deliver, xfer;

  // in_ready held low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive_q <= 1'b0;
    else        alive_q <= 1'b1;
  end

  assign in_ready = alive_q && !full;
  assign push     = in_valid && in_ready;

  noc_sync_fifo #(
    .WIDTH(WIDTH_packet),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(in_data),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  // Route the FIFO head: matching prefix goes down to a child, anything else goes up.
  always_comb begin
    dest_ext           = MaxDestW'(head[WIDTH_packet-1 -: WIDTH_dest]);
    addr_ext           = MaxDestW'(ADDR);
    prefix_match       = (P == 0) ||
                         (dest_slice(dest_ext, WIDTH_dest - 1, P) ==
                          dest_slice(addr_ext, WIDTH_dest - 1, P));
    head_route.port    = prefix_match ? PortIdxW'(dest_slice(dest_ext, WIDTH_dest - 1 - P, CBITS))
                                      : PortIdxW'(NUM_CHILD);
    head_route.illegal = !prefix_match && (IS_ROOT || FROM_PARENT);
  end

  assign xfer = |(valid_q & out_ready);

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next state plus FIFO pop / load / drop decisions; at most one pop per cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    drop    = 1'b0;
    deliver = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_route.illegal) begin
            drop = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (xfer) begin
          deliver = 1'b1;
          if (!empty) begin
            pop = 1'b1;
            if (head_route.illegal) begin
              drop    = 1'b1;
              state_d = StIdle;
            end else begin
              load = 1'b1;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Held packet, its one-hot target, and the saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      if (load) begin
        data_q  <= head;
        valid_q <= {{(NUM_OUT-1){1'b0}}, 1'b1} << head_route.port;
      end
      if (deliver && pkt_q != 16'hFFFF) pkt_q <= pkt_q + 16'd1;
      if (drop && err_q != 16'hFFFF)    err_q <= err_q + 16'd1;
    end
  end

  // Outputs: out_valid only while a packet is held.
  always_comb begin
    out_valid = (state_q == StHold) ? valid_q : '0;
    out_data  = data_q;
    pkt_count = pkt_q;
    err_count = err_q;
  end

endmodule

// File: tb/tb_input_ctrl_nway.sv
// Scoreboard bench for input_ctrl_nway (level-1 router, address 100, binary tree).
module tb_input_ctrl_nway;

  typedef struct {
    logic [13:0] data;
    logic [2:0]  valid;
  } exp_t;

  typedef struct {
    logic [13:0] data;
    logic [2:0]  valid;
    int          cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] in_data;
  logic        in_valid, fp_valid;
  logic [2:0]  out_ready;
  logic        in_ready, fp_in_ready;
  logic [13:0] out_data, fp_out_data;
  logic [2:0]  out_valid, fp_out_valid;
  logic [15:0] pkt_count, err_count, fp_pkt_count, fp_err_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t exp_q[$];
  obs_t obs_q[$];

  input_ctrl_nway #(
    .WIDTH_packet(14), .WIDTH_dest(3), .CBITS(1), .LEVEL(1), .ADDR(3'b100),
    .IS_ROOT(1'b0), .FROM_PARENT(1'b0), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  input_ctrl_nway #(
    .WIDTH_packet(14), .WIDTH_dest(3), .CBITS(1), .LEVEL(1), .ADDR(3'b100),
    .IS_ROOT(1'b0), .FROM_PARENT(1'b1), .DEPTH(4)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(fp_valid), .in_ready(fp_in_ready),
    .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(out_ready),
    .pkt_count(fp_pkt_count), .err_count(fp_err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference route for level 1, address 100: top dest bit selects child vs parent.
  function automatic logic [2:0] model_port(input logic [13:0] d, input bit from_parent);
    logic [2:0] dst;
    dst = d[13:11];
    if (dst[2]) return dst[1] ? 3'b010 : 3'b001;
    return from_parent ? 3'b000 : 3'b100;
  endfunction

  // Handshakes seen at negedge complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back('{data: in_data, valid: model_port(in_data, 1'b0)});
      if ((out_valid & out_ready) != 3'b000)
        obs_q.push_back('{data: out_data, valid: out_valid, cyc: cyc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [13:0] d, input bit to_fp, output bit ok);
    ok      = 1'b0;
    in_data = d;
    if (to_fp) fp_valid = 1'b1;
    else       in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (to_fp ? fp_in_ready : in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    fp_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    fp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL reset_out_valid: got %b want 000", out_valid); end
    checks++; if (out_data !== 14'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++; if (pkt_count !== 16'h0 || err_count !== 16'h0) begin
      failures++; $display("FAIL reset_counters: got pkt=%h err=%h want 0/0", pkt_count, err_count);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    bit ok;
    exp_t e;
    obs_t o;
    out_ready = 3'b111;
    send(14'h2C55, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_accept: got timeout want accept"); end
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL single_no_bypass: got %b want 000", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 3'b001 || out_data !== 14'h2C55) begin
      failures++; $display("FAIL single_out: got %b/%h want 001/2c55", out_valid, out_data);
    end
    @(posedge clk); #1;
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL single_pkt_count: got %0d want 1", pkt_count); end
    wait_obs(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got 0 outputs want 1"); end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL single_sb: got unexpected %h want none", o.data);
      end else begin
        e = exp_q.pop_front();
        if (o.data !== e.data || o.valid !== e.valid) begin
          failures++; $display("FAIL single_sb: got %h/%b want %h/%b", o.data, o.valid, e.data, e.valid);
        end
      end
    end
  endtask

  task automatic test_routing();
    bit ok, ok2;
    exp_t e;
    obs_t o;
    int last_cyc;
    do_reset();
    out_ready = 3'b111;
    send(14'h3000, 1'b0, ok);
    send(14'h1800, 1'b0, ok2);
    checks++; if (!(ok && ok2)) begin failures++; $display("FAIL routing_accept: got timeout want accept"); end
    wait_obs(2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL routing_timeout: got %0d outputs want 2", obs_q.size()); end
    checks++; if (pkt_count !== 16'd2) begin failures++; $display("FAIL routing_pkt_count: got %0d want 2", pkt_count); end
    last_cyc = -1;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL routing_sb: got unexpected %h want none", o.data);
      end else begin
        e = exp_q.pop_front();
        if (o.data !== e.data || o.valid !== e.valid || o.cyc <= last_cyc) begin
          failures++; $display("FAIL routing_sb: got %h/%b want %h/%b", o.data, o.valid, e.data, e.valid);
        end
      end
      last_cyc = o.cyc;
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] pk [6];
    bit ok, all_ok;
    exp_t e;
    obs_t o;
    int cycs[$];
    bit consec;
    pk = '{14'h2C55, 14'h3000, 14'h1800, 14'h2ABC, 14'h3FFF, 14'h0123};
    do_reset();
    out_ready = 3'b000;
    all_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(pk[i], 1'b0, ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) begin failures++; $display("FAIL bp_accept5: got timeout want accept"); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full: got in_ready=%b want 0", in_ready); end
    // Stall with only the non-target ports ready; the held packet must not move.
    out_ready = ~model_port(pk[0], 1'b0);
    in_data   = pk[5];
    in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 5) begin failures++; $display("FAIL bp_no_accept: got %0d accepted want 5", exp_q.size()); end
    checks++; if (out_valid !== model_port(pk[0], 1'b0) || out_data !== pk[0]) begin
      failures++; $display("FAIL bp_stable: got %b/%h want %b/%h", out_valid, out_data, model_port(pk[0], 1'b0), pk[0]);
    end
    checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL bp_ignore_ready: got pkt=%0d want 0", pkt_count); end
    out_ready = 3'b111;
    send(pk[5], 1'b0, ok);
    wait_obs(6, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: got %0d outputs want 6", obs_q.size()); end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      cycs.push_back(o.cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL bp_sb: got unexpected %h want none", o.data);
      end else begin
        e = exp_q.pop_front();
        if (o.data !== e.data || o.valid !== e.valid) begin
          failures++; $display("FAIL bp_sb: got %h/%b want %h/%b", o.data, o.valid, e.data, e.valid);
        end
      end
    end
    consec = (cycs.size() >= 5);
    for (int i = 1; i < 5 && i < cycs.size(); i++) if (cycs[i] != cycs[i-1] + 1) consec = 1'b0;
    checks++; if (!consec) begin failures++; $display("FAIL bp_consecutive: got non-consecutive delivery want one per cycle"); end
  endtask

  task automatic test_from_parent();
    bit ok, seen, found;
    do_reset();
    out_ready = 3'b111;
    send(14'h1800, 1'b1, ok);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (fp_out_valid !== 3'b000) seen = 1'b1;
    end
    checks++; if (!ok || seen) begin failures++; $display("FAIL fp_drop: got seen=%b accept=%b want 0/1", seen, ok); end
    checks++; if (fp_err_count !== 16'd1) begin failures++; $display("FAIL fp_err_count: got %0d want 1", fp_err_count); end
    checks++; if (fp_pkt_count !== 16'd0) begin failures++; $display("FAIL fp_pkt_zero: got %0d want 0", fp_pkt_count); end
    send(14'h2C55, 1'b1, ok);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fp_out_valid !== 3'b000) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (!found || fp_out_valid !== 3'b001 || fp_out_data !== 14'h2C55) begin
      failures++; $display("FAIL fp_route: got %b/%h want 001/2c55", fp_out_valid, fp_out_data);
    end
    @(posedge clk); #1;
    checks++; if (fp_pkt_count !== 16'd1) begin failures++; $display("FAIL fp_pkt_count: got %0d want 1", fp_pkt_count); end
  endtask

  task automatic test_reset_mid();
    bit ok, all_ok;
    exp_t e;
    obs_t o;
    do_reset();
    out_ready = 3'b111;
    send(14'h3000, 1'b0, ok);
    wait_obs(1, ok);
    obs_q.delete();
    exp_q.delete();
    out_ready = 3'b000;
    all_ok = 1'b1;
    send(14'h2C55, 1'b0, ok); all_ok &= ok;
    send(14'h1800, 1'b0, ok); all_ok &= ok;
    send(14'h3FFF, 1'b0, ok); all_ok &= ok;
    send(14'h0123, 1'b0, ok); all_ok &= ok;
    checks++; if (!all_ok || out_valid !== 3'b001 || pkt_count !== 16'd1) begin
      failures++; $display("FAIL mid_setup: got %b pkt=%0d want 001 pkt=1", out_valid, pkt_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 3'b000 || out_data !== 14'h0) begin
      failures++; $display("FAIL mid_reset_out: got %b/%h want 000/0000", out_valid, out_data);
    end
    checks++; if (pkt_count !== 16'd0 || err_count !== 16'd0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state: got pkt=%0d err=%0d rdy=%b want 0/0/0", pkt_count, err_count, in_ready);
    end
    exp_q.delete();
    obs_q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 3'b111;
    send(14'h3000, 1'b0, ok);
    wait_obs(1, ok);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (obs_q.size() != 1 || pkt_count !== 16'd1) begin
      failures++; $display("FAIL mid_after: got %0d outputs pkt=%0d want 1/1", obs_q.size(), pkt_count);
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL mid_sb: got unexpected %h want none", o.data);
      end else begin
        e = exp_q.pop_front();
        if (o.data !== e.data || o.valid !== e.valid) begin
          failures++; $display("FAIL mid_sb: got %h/%b want %h/%b", o.data, o.valid, e.data, e.valid);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    fp_valid  = 1'b0;
    out_ready = 3'b000;
    test_reset();
    test_single();
    test_routing();
    test_backpressure();
    test_from_parent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
